// File: rtl/score_display_scanner_pkg.sv
// Shared constants, conversion FSM states and the BCD digit-adjust helper
// for the score display scanner.
package score_display_scanner_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned SCORE_W    = 14;
  localparam logic [3:0]  BLANK_CODE = 4'hF;
  localparam logic [13:0] SCORE_MAX  = 14'd9999;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_e;

  // Double-dabble correction: any BCD nibble >= 5 gets +3 before the shift.
  function automatic logic [15:0] add3_nibbles(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (b[k*4 +: 4] >= 4'd5) r[k*4 +: 4] = b[k*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/score_display_scanner_if.sv
// Score load / display bus between score logic (master) and the scanner (slave).
interface score_display_scanner_if
  import score_display_scanner_pkg::*;
;
  logic               score_valid;
  logic [SCORE_W-1:0] score_in;
  logic               busy;
  logic [3:0]         digit;
  logic [3:0]         an;

  modport master (output score_valid, score_in, input busy, digit, an);
  modport slave  (input score_valid, score_in, output busy, digit, an);
endinterface

// File: rtl/score_display_scanner_bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter: 14 shift cycles plus a
// DONE cycle that publishes the result on bcd with a one-cycle done pulse.
module bin2bcd_seq
  import score_display_scanner_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [SCORE_W-1:0] bin,
  output logic               busy,
  output logic               done,
  output logic [15:0]        bcd
);

  conv_state_e        state_q, state_d;
  logic [3:0]         iter_q, iter_d;
  logic [SCORE_W-1:0] bin_q, bin_d;
  logic [15:0]        scr_q, scr_d;
  logic [15:0]        bcd_q, bcd_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [29:0]        shifted;

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    bcd_d   = bcd_q;
    done_d  = 1'b0;
    shifted = {add3_nibbles(scr_q), bin_q} << 1;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          bin_d   = bin;
          scr_d   = '0;
          iter_d  = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        {scr_d, bin_d} = shifted;
        iter_d = iter_q + 4'd1;
        if (iter_q == 4'd13) state_d = ST_DONE;
      end
      ST_DONE: begin
        bcd_d   = scr_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      iter_q  <= '0;
      bin_q   <= '0;
      scr_q   <= '0;
      bcd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      bcd_q   <= bcd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: rtl/score_display_scanner.sv
// Score to 4-digit multiplexed display feeder: saturates the score, converts
// to BCD, holds the shown value and scans digits with active-low anodes.
module score_display_scanner
  import score_display_scanner_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter bit          BLANK_LZ    = 1'b1
) (
  input logic                   clk,
  input logic                   rst_n,
  score_display_scanner_if.slave bus
);

  localparam int unsigned     CNT_W    = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [SCORE_W-1:0]    score_sat;
  logic                  conv_busy, conv_done;
  logic [15:0]           conv_bcd;
  logic [15:0]           shown_q, shown_d;
  logic [CNT_W-1:0]      refresh_q, refresh_d;
  logic [1:0]            idx_q, idx_d;
  logic [3:0]            an_q, an_d;
  logic [3:0]            digit_q, digit_d;
  logic [NUM_DIGITS-1:0] blank;

  assign score_sat = (bus.score_in > SCORE_MAX) ? SCORE_MAX : bus.score_in;

  bin2bcd_seq u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (bus.score_valid),
    .bin   (score_sat),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_comb begin
    shown_d   = conv_done ? conv_bcd : shown_q;
    refresh_d = refresh_q + CNT_W'(1);
    idx_d     = idx_q;
    if (refresh_q == CNT_LAST) begin
      refresh_d = '0;
      idx_d     = idx_q + 2'd1;
    end
    // A nibble is a leading zero only if every nibble above it is zero too.
    blank    = '0;
    blank[3] = (shown_q[15:12] == 4'd0);
    blank[2] = blank[3] && (shown_q[11:8] == 4'd0);
    blank[1] = blank[2] && (shown_q[7:4] == 4'd0);
    an_d     = ~(4'b0001 << idx_d);
    digit_d  = (BLANK_LZ && blank[idx_d]) ? BLANK_CODE : shown_q[{idx_d, 2'b00} +: 4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shown_q   <= '0;
      refresh_q <= '0;
      idx_q     <= '0;
      an_q      <= 4'b1110;
      digit_q   <= 4'h0;
    end else begin
      shown_q   <= shown_d;
      refresh_q <= refresh_d;
      idx_q     <= idx_d;
      an_q      <= an_d;
      digit_q   <= digit_d;
    end
  end

  assign bus.busy  = conv_busy;
  assign bus.an    = an_q;
  assign bus.digit = digit_q;

endmodule
